// File: rtl/result_engine_if.sv
// rtl/result_engine_if.sv - controller/consumer handshake bundle for result_engine
// master drives start/start_address; slave (the engine) drives the results.
interface result_engine_if;
   logic        start;
   logic [3:0]  start_address;
   logic [3:0]  dout;
   logic [15:0] out;
   logic        finish;

   modport master (
      output start,
      output start_address,
      input  dout,
      input  out,
      input  finish
   );

   modport slave (
      input  start,
      input  start_address,
      output dout,
      output out,
      output finish
   );
endinterface

// File: rtl/result_engine.sv
// rtl/result_engine.sv - sequential sum-of-squares over COUNT words of a 16x4 memory
module result_engine #(
   parameter int COUNT = 4
) (
   input  logic              clk,
   input  logic              rst,
   result_engine_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [4:0] CNT_LAST = 5'(COUNT - 1);

   state_t      r_state;
   logic [3:0]  r_addr;
   logic [4:0]  r_cnt;
   logic [15:0] r_out;
   logic [3:0]  r_dout;
   logic        r_finish;

   state_t      w_state_n;
   logic [3:0]  w_addr_n;
   logic [4:0]  w_cnt_n;
   logic [15:0] w_out_n;
   logic [3:0]  w_dout_n;
   logic        w_finish_n;

   logic [3:0]  w_word;
   logic [7:0]  w_sq;
   logic [3:0]  w_mem [16];

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_mem[i] = 4'(i);
      end
   end

   assign w_word = w_mem[r_addr];

   assign w_sq = {4'd0, w_word} * {4'd0, w_word};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= 4'd0;
         r_cnt    <= 5'd0;
         r_out    <= 16'd0;
         r_dout   <= 4'd0;
         r_finish <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_addr   <= w_addr_n;
         r_cnt    <= w_cnt_n;
         r_out    <= w_out_n;
         r_dout   <= w_dout_n;
         r_finish <= w_finish_n;
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_addr_n   = r_addr;
      w_cnt_n    = r_cnt;
      w_out_n    = r_out;
      w_dout_n   = r_dout;
      w_finish_n = r_finish;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_addr_n   = bus.start_address;
               w_cnt_n    = 5'd0;
               w_out_n    = 16'd0;
               w_dout_n   = 4'd0;
               w_finish_n = 1'b0;
               w_state_n  = S_RUN;
            end
         end
         S_RUN: begin
            w_out_n  = r_out + {8'd0, w_sq};
            w_dout_n = w_word;
            w_addr_n = r_addr + 4'd1;
            w_cnt_n  = r_cnt + 5'd1;
            if (r_cnt == CNT_LAST) begin
               w_finish_n = 1'b1;
               w_state_n  = S_DONE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   assign bus.dout   = r_dout;
   assign bus.out    = r_out;
   assign bus.finish = r_finish;

endmodule

// File: tb/tb_result_engine.sv
// tb/tb_result_engine.sv - self-checking bench for result_engine (COUNT=4 and COUNT=16 instances)
// Expected values come from a plain-arithmetic sum-of-squares model over mem[i] = i.
module tb_result_engine;

   logic clk;
   logic rst;
   int   checks;
   int   passed;

   result_engine_if ifa ();
   result_engine_if ifb ();

   result_engine #(.COUNT(4))  dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   result_engine #(.COUNT(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] exp_out;
      logic [3:0]  exp_dout;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Sum of squares of k consecutive words starting at a, wrapping mod 16.
   function automatic void model(input int a, input int k, output int s, output int d);
      s = 0;
      d = 0;
      for (int i = 0; i < k; i++) begin
         d = (a + i) % 16;
         s = s + d * d;
      end
   endfunction

   task automatic drive(input int sel, input logic st, input logic [3:0] a);
      if (sel == 0) begin ifa.start = st; ifa.start_address = a; end
      else          begin ifb.start = st; ifb.start_address = a; end
   endtask

   task automatic sample(input int sel, output int o, output int d, output int f);
      if (sel == 0) begin o = ifa.out; d = ifa.dout; f = ifa.finish; end
      else          begin o = ifb.out; d = ifb.dout; f = ifb.finish; end
   endtask

   // One-cycle start pulse, then check partial sums and finish timing edge by edge.
   task automatic do_run(input int sel, input logic [3:0] a, input int n, input string tag);
      int o, d, f, es, ed;
      @(negedge clk);
      drive(sel, 1'b1, a);
      @(negedge clk);
      drive(sel, 1'b0, 4'd0);
      sample(sel, o, d, f);
      check({tag, " e0 finish"}, f, 0);
      check({tag, " e0 out"}, o, 0);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         sample(sel, o, d, f);
         model(a, k, es, ed);
         check($sformatf("%s e%0d out", tag, k), o, es);
         check($sformatf("%s e%0d dout", tag, k), d, ed);
         check($sformatf("%s e%0d finish", tag, k), f, (k == n) ? 1 : 0);
      end
   endtask

   initial begin
      int o, d, f, es, ed;
      logic [3:0] ra;
      checks = 0;
      passed = 0;
      rst = 1'b1;
      drive(0, 1'b0, 4'd0);
      drive(1, 1'b0, 4'd0);

      vecs[0] = '{4'd0,  16'd14,  4'd3};
      vecs[1] = '{4'd14, 16'd422, 4'd1};
      vecs[2] = '{4'd1,  16'd30,  4'd4};
      vecs[3] = '{4'd2,  16'd54,  4'd5};
      vecs[4] = '{4'd12, 16'd734, 4'd15};

      repeat (2) @(negedge clk);
      sample(0, o, d, f);
      check("reset out", o, 0);
      check("reset dout", d, 0);
      check("reset finish", f, 0);
      rst = 1'b0;

      // Table: each run ends in DONE, so later entries also exercise restart from DONE.
      for (int i = 0; i < 5; i++) begin
         do_run(0, vecs[i].addr, 4, $sformatf("vec%0d", i));
         sample(0, o, d, f);
         check($sformatf("vec%0d table out", i), o, int'(vecs[i].exp_out));
         check($sformatf("vec%0d table dout", i), d, int'(vecs[i].exp_dout));
      end

      do_run(1, 4'd5, 16, "c16");
      sample(1, o, d, f);
      check("c16 out", o, 1240);
      check("c16 dout", d, 4);

      // Start during RUN is ignored.
      @(negedge clk); drive(0, 1'b1, 4'd0);
      @(negedge clk); drive(0, 1'b0, 4'd0);
      @(negedge clk); @(negedge clk);
      drive(0, 1'b1, 4'd9);
      @(negedge clk); drive(0, 1'b0, 4'd0);
      sample(0, o, d, f);
      check("ign e3 finish", f, 0);
      @(negedge clk);
      sample(0, o, d, f);
      check("ign finish", f, 1);
      check("ign out", o, 14);
      check("ign dout", d, 3);
      @(negedge clk);
      sample(0, o, d, f);
      check("ign hold finish", f, 1);
      check("ign hold out", o, 14);

      // Reset mid-run aborts.
      @(negedge clk); drive(0, 1'b1, 4'd7);
      @(negedge clk); drive(0, 1'b0, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sample(0, o, d, f);
      check("rst mid out", o, 0);
      check("rst mid dout", d, 0);
      check("rst mid finish", f, 0);
      rst = 1'b0;
      @(negedge clk);
      sample(0, o, d, f);
      check("rst idle finish", f, 0);
      do_run(0, 4'd2, 4, "post_rst");
      sample(0, o, d, f);
      check("post_rst out", o, 54);
      check("post_rst dout", d, 5);

      // Start held high: finish high for one cycle between back-to-back runs.
      @(negedge clk); drive(0, 1'b1, 4'd3);
      model(3, 4, es, ed);
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         sample(0, o, d, f);
         if (k == 4 || k == 9) begin
            check($sformatf("b2b k%0d finish", k), f, 1);
            check($sformatf("b2b k%0d out", k), o, es);
         end else begin
            check($sformatf("b2b k%0d finish", k), f, 0);
         end
      end
      drive(0, 1'b0, 4'd0);
      repeat (6) @(negedge clk);

      for (int r = 0; r < 20; r++) begin
         ra = 4'($urandom_range(0, 15));
         do_run(0, ra, 4, $sformatf("rnd%0d a%0d", r, ra));
      end
      for (int r = 0; r < 4; r++) begin
         ra = 4'($urandom_range(0, 15));
         do_run(1, ra, 16, $sformatf("rnd16_%0d a%0d", r, ra));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
